// File: rtl/alu_issue.sv
// Single-issue RV32I integer/branch sequencer: decodes one instruction, drives an
// external registered ALU for one cycle and hands the result to writeback.
module alu_issue #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            alu_req,
    output logic [4:0]      alu_op,
    output logic [XLEN-1:0] alu_lhs,
    output logic [XLEN-1:0] alu_rhs,
    input  logic [XLEN-1:0] alu_res,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_data,
    output logic            out_we,
    output logic            out_taken,
    output logic            out_illegal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_CAPT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
    localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_EQ = 5'd10,  OP_NEQ = 5'd11;
    localparam logic [4:0] OP_LT = 5'd12,  OP_GE = 5'd13,  OP_LTU = 5'd14, OP_GEU = 5'd15;

    localparam logic [6:0] OPC_OP = 7'b0110011, OPC_IMM = 7'b0010011, OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111, OPC_BRANCH = 7'b1100011;

    // Shared funct3 -> ALU op mapping for OP and OP-IMM; alt selects SUB / SRA.
    function automatic logic [4:0] arith_op(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'b000:  op = alt ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = alt ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

    logic [1:0]      state_q, state_d;
    logic [4:0]      alu_op_q, alu_op_d, out_rd_q, out_rd_d;
    logic [XLEN-1:0] alu_lhs_q, alu_lhs_d, alu_rhs_q, alu_rhs_d, out_data_q, out_data_d;
    logic            is_br_q, is_br_d, out_we_q, out_we_d;
    logic            out_taken_q, out_taken_d, out_illegal_q, out_illegal_d;

    logic [6:0]      f7_s;
    logic [2:0]      f3_s;
    logic [XLEN-1:0] imm_i_s, imm_u_s, imm_b_s, dec_lhs_s, dec_rhs_s;
    logic [4:0]      dec_op_s;
    logic            dec_legal_s, dec_br_s;

    assign f7_s    = instr[31:25];
    assign f3_s    = instr[14:12];
    assign imm_i_s = {{20{instr[31]}}, instr[31:20]};
    assign imm_u_s = {instr[31:12], 12'h000};
    assign imm_b_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

    // Instruction decode into ALU op, operands and legality.
    always_comb begin
        dec_legal_s = 1'b0;
        dec_br_s    = 1'b0;
        dec_op_s    = OP_ADD;
        dec_lhs_s   = rs1_val;
        dec_rhs_s   = rs2_val;
        case (instr[6:0])
            OPC_OP: begin
                if ((f7_s == 7'b0000000) ||
                    ((f7_s == 7'b0100000) && ((f3_s == 3'b000) || (f3_s == 3'b101)))) begin
                    dec_legal_s = 1'b1;
                end else begin
                    dec_legal_s = 1'b0;
                end
                dec_op_s = arith_op(f3_s, instr[30]);
                if ((f3_s == 3'b001) || (f3_s == 3'b101)) begin
                    dec_rhs_s = {27'd0, rs2_val[4:0]};
                end else begin
                    dec_rhs_s = rs2_val;
                end
            end
            OPC_IMM: begin
                case (f3_s)
                    3'b001:  dec_legal_s = (f7_s == 7'b0000000);
                    3'b101:  dec_legal_s = (f7_s == 7'b0000000) || (f7_s == 7'b0100000);
                    default: dec_legal_s = 1'b1;
                endcase
                // Bit 30 is an immediate bit except for SRAI, so it only steers funct3 101.
                dec_op_s = arith_op(f3_s, (f3_s == 3'b101) && instr[30]);
                if ((f3_s == 3'b001) || (f3_s == 3'b101)) begin
                    dec_rhs_s = {27'd0, instr[24:20]};
                end else begin
                    dec_rhs_s = imm_i_s;
                end
            end
            OPC_LUI: begin
                dec_legal_s = 1'b1;
                dec_lhs_s   = 32'd0;
                dec_rhs_s   = imm_u_s;
            end
            OPC_AUIPC: begin
                dec_legal_s = 1'b1;
                dec_lhs_s   = pc;
                dec_rhs_s   = imm_u_s;
            end
            OPC_BRANCH: begin
                dec_br_s    = 1'b1;
                dec_legal_s = 1'b1;
                case (f3_s)
                    3'b000:  dec_op_s = OP_EQ;
                    3'b001:  dec_op_s = OP_NEQ;
                    3'b100:  dec_op_s = OP_LT;
                    3'b101:  dec_op_s = OP_GE;
                    3'b110:  dec_op_s = OP_LTU;
                    3'b111:  dec_op_s = OP_GEU;
                    default: dec_legal_s = 1'b0;
                endcase
            end
            default: dec_legal_s = 1'b0;
        endcase
    end

    // Sequencer next state and result/operand register updates.
    always_comb begin
        state_d       = state_q;
        alu_op_d      = alu_op_q;
        alu_lhs_d     = alu_lhs_q;
        alu_rhs_d     = alu_rhs_q;
        is_br_d       = is_br_q;
        out_rd_d      = out_rd_q;
        out_data_d    = out_data_q;
        out_we_d      = out_we_q;
        out_taken_d   = out_taken_q;
        out_illegal_d = out_illegal_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    alu_op_d      = dec_op_s;
                    alu_lhs_d     = dec_lhs_s;
                    alu_rhs_d     = dec_rhs_s;
                    is_br_d       = dec_br_s;
                    out_rd_d      = instr[11:7];
                    out_illegal_d = !dec_legal_s;
                    out_taken_d   = 1'b0;
                    out_we_d      = dec_legal_s && !dec_br_s && (instr[11:7] != 5'd0);
                    // Branch target is known at decode; CAPT then only supplies the condition.
                    out_data_d    = (dec_legal_s && dec_br_s) ? (pc + imm_b_s) : 32'd0;
                    state_d       = dec_legal_s ? S_EXEC : S_OUT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: state_d = S_CAPT;
            S_CAPT: begin
                if (is_br_q) begin
                    out_taken_d = alu_res[0];
                end else begin
                    out_data_d = alu_res;
                end
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            alu_op_q      <= 5'd0;
            alu_lhs_q     <= 32'd0;
            alu_rhs_q     <= 32'd0;
            is_br_q       <= 1'b0;
            out_rd_q      <= 5'd0;
            out_data_q    <= 32'd0;
            out_we_q      <= 1'b0;
            out_taken_q   <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_op_q      <= alu_op_d;
            alu_lhs_q     <= alu_lhs_d;
            alu_rhs_q     <= alu_rhs_d;
            is_br_q       <= is_br_d;
            out_rd_q      <= out_rd_d;
            out_data_q    <= out_data_d;
            out_we_q      <= out_we_d;
            out_taken_q   <= out_taken_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign alu_req     = (state_q == S_EXEC);
    assign out_valid   = (state_q == S_OUT);
    assign alu_op      = alu_op_q;
    assign alu_lhs     = alu_lhs_q;
    assign alu_rhs     = alu_rhs_q;
    assign out_rd      = out_rd_q;
    assign out_data    = out_data_q;
    assign out_we      = out_we_q;
    assign out_taken   = out_taken_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed corner cases plus random RV32I traffic
// checked against an instruction-semantics reference model.
module tb_alu_issue;

    logic        clk, reset, in_valid, in_ready, alu_req, out_valid, out_ready;
    logic [31:0] instr, pc, rs1_val, rs2_val, alu_lhs, alu_rhs, alu_res, out_data;
    logic [4:0]  alu_op, out_rd;
    logic        out_we, out_taken, out_illegal;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic        taken;
        logic        ill;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic rdy_force = 1'b0;
    logic rdy_val = 1'b1;

    alu_issue #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .alu_req(alu_req), .alu_op(alu_op), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs),
        .alu_res(alu_res), .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_data(out_data), .out_we(out_we),
        .out_taken(out_taken), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External registered ALU the block talks to.
    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] l, input logic [31:0] r);
        logic [31:0] v;
        case (op)
            5'd0:  v = l + r;
            5'd1:  v = l - r;
            5'd2:  v = l << r[4:0];
            5'd3:  v = {31'd0, $signed(l) < $signed(r)};
            5'd4:  v = {31'd0, l < r};
            5'd5:  v = l ^ r;
            5'd6:  v = l >> r[4:0];
            5'd7:  v = $signed(l) >>> r[4:0];
            5'd8:  v = l | r;
            5'd9:  v = l & r;
            5'd10: v = {31'd0, l == r};
            5'd11: v = {31'd0, l != r};
            5'd12: v = {31'd0, $signed(l) < $signed(r)};
            5'd13: v = {31'd0, $signed(l) >= $signed(r)};
            5'd14: v = {31'd0, l < r};
            5'd15: v = {31'd0, l >= r};
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    always @(posedge clk) if (alu_req) alu_res <= alu_f(alu_op, alu_lhs, alu_rhs);

    // Architectural effect of one instruction, straight from the ISA rules.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [31:0] imm, r, bt;
        logic [12:0] b13;
        logic [4:0] sh;
        logic ok, br, t;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = i[14:12]; f7 = i[31:25];
        imm = {{20{i[31]}}, i[31:20]};
        b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        bt = p + {{19{b13[12]}}, b13};
        ok = 1'b0; br = 1'b0; t = 1'b0; r = 32'd0;
        case (i[6:0])
            7'h33, 7'h13: begin
                if (i[6:0] == 7'h33) begin
                    ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                    sh = b[4:0];
                end else begin
                    ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                         (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                    sh = i[24:20];
                    b = imm;
                end
                case (f3)
                    3'd0: r = (i[6:0] == 7'h33 && i[30]) ? a - b : a + b;
                    3'd1: r = a << sh;
                    3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: r = (a < b) ? 32'd1 : 32'd0;
                    3'd4: r = a ^ b;
                    3'd5: begin
                        if (i[30]) r = $signed(a) >>> sh;
                        else r = a >> sh;
                    end
                    3'd6: r = a | b;
                    default: r = a & b;
                endcase
            end
            7'h37: begin ok = 1'b1; r = {i[31:12], 12'h000}; end
            7'h17: begin ok = 1'b1; r = p + {i[31:12], 12'h000}; end
            7'h63: begin
                br = 1'b1; ok = 1'b1; r = bt;
                case (f3)
                    3'd0: t = (a == b);
                    3'd1: t = (a != b);
                    3'd4: t = ($signed(a) < $signed(b));
                    3'd5: t = ($signed(a) >= $signed(b));
                    3'd6: t = (a < b);
                    3'd7: t = (a >= b);
                    default: ok = 1'b0;
                endcase
            end
            default: ok = 1'b0;
        endcase
        e.rd = i[11:7];
        e.ill = !ok;
        e.data = ok ? r : 32'd0;
        e.taken = ok && t;
        e.we = ok && !br && (i[11:7] != 5'd0);
        e.acc = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    // Present one instruction; returns #1 after the accepting edge.
    task automatic issue(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        wait_idle();
        if (in_ready) begin
            e = model(i, p, a, b);
            e.acc = cyc;
            sb.push_back(e);
            in_valid = 1'b1; instr = i; pc = p; rs1_val = a; rs2_val = b;
            @(posedge clk); #1;
            in_valid = 1'b0; instr = $urandom;
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 6))
            0, 1: begin
                w[6:0] = 7'h33;
                if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
            end
            2: begin
                w[6:0] = 7'h13;
                if ($urandom_range(0, 2) != 0) w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
            end
            3: w[6:0] = 7'h37;
            4: w[6:0] = 7'h17;
            5: w[6:0] = 7'h63;
            default: ;
        endcase
        return w;
    endfunction

    // Writeback acceptance pattern.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on each new result and checks it stays stable.
    exp_t cur;
    logic seen = 1'b0, idle_next = 1'b0;
    int nreq = 0;
    logic [31:0] s_data;
    logic [4:0] s_rd;
    logic s_we, s_taken, s_ill;
    always @(negedge clk) begin
        if (reset) begin
            seen = 1'b0; idle_next = 1'b0; nreq = 0;
        end else begin
            if (alu_req) nreq++;
            if (out_valid) begin
                chk("in_ready_in_out", {31'd0, in_ready}, 32'd0);
                if (!seen) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
                    end else begin
                        cur = sb.pop_front();
                        chk("out_rd", {27'd0, out_rd}, {27'd0, cur.rd});
                        chk("out_data", out_data, cur.data);
                        chk("out_we", {31'd0, out_we}, {31'd0, cur.we});
                        chk("out_taken", {31'd0, out_taken}, {31'd0, cur.taken});
                        chk("out_illegal", {31'd0, out_illegal}, {31'd0, cur.ill});
                        chk("latency", cyc - cur.acc, cur.ill ? 32'd1 : 32'd3);
                        chk("alu_req_count", nreq, cur.ill ? 32'd0 : 32'd1);
                    end
                    nreq = 0; seen = 1'b1;
                    s_data = out_data; s_rd = out_rd; s_we = out_we; s_taken = out_taken; s_ill = out_illegal;
                end else begin
                    chk("hold_data", out_data, s_data);
                    chk("hold_ctl", {24'd0, out_rd, out_we, out_taken, out_illegal},
                        {24'd0, s_rd, s_we, s_taken, s_ill});
                end
                if (out_ready) begin seen = 1'b0; idle_next = 1'b1; end
            end else if (idle_next) begin
                chk("idle_after_handshake", {31'd0, in_ready}, 32'd1);
                idle_next = 1'b0;
            end
        end
    end

    initial begin
        int n;
        logic [31:0] a;
        reset = 1'b1; in_valid = 1'b0; instr = 32'd0; pc = 32'd0; rs1_val = 32'd0; rs2_val = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_outs", {26'd0, out_valid, alu_req, out_we, out_taken, out_illegal, 1'b0}, 32'd0);
        chk("rst_data", out_data | alu_lhs | alu_rhs | {27'd0, out_rd} | {27'd0, alu_op}, 32'd0);
        reset = 1'b0;

        issue(32'h002081B3, 32'h0, 32'd5, 32'd7);
        chk("add_req", {31'd0, alu_req}, 32'd1);
        chk("add_op", {27'd0, alu_op}, 32'd0);
        @(posedge clk); #1;
        chk("add_req_once", {31'd0, alu_req}, 32'd0);

        issue(32'h4020D2B3, 32'h40, 32'h80000000, 32'h00000024);
        chk("sra_op", {27'd0, alu_op}, 32'd7);
        chk("sra_rhs", alu_rhs, 32'd4);

        issue(32'h0020C463, 32'h100, 32'hFFFFFFFF, 32'd1);
        chk("blt_op", {27'd0, alu_op}, 32'd12);

        issue(32'hFFFFFFFF, 32'h200, 32'd1, 32'd2);
        chk("ill_no_req", {31'd0, alu_req}, 32'd0);
        chk("ill_valid_next", {31'd0, out_valid}, 32'd1);

        // Writeback stall held well beyond five cycles.
        wait_idle();
        rdy_force = 1'b1; rdy_val = 1'b0;
        issue(32'h00A00513, 32'h0, 32'd0, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        rdy_val = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rdy_force = 1'b0;

        // Reset while executing drops the instruction.
        issue(32'h002081B3, 32'h0, 32'd9, 32'd9);
        reset = 1'b1;
        sb.delete(sb.size() - 1);
        @(posedge clk); #1;
        chk("rst_exec_idle", {31'd0, in_ready}, 32'd1);
        chk("rst_exec_outs", {27'd0, out_valid, alu_req, out_we, out_taken, out_illegal}, 32'd0);
        chk("rst_exec_data", out_data, 32'd0);
        reset = 1'b0;

        // Reset wins over a simultaneous in_valid.
        in_valid = 1'b1; instr = 32'h002081B3; reset = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; reset = 1'b0;
        chk("rst_prio_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("rst_prio_no_req", {31'd0, alu_req}, 32'd0);

        for (int k = 0; k < 250; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = a & 32'h0000000F;
            issue(gen_instr(), $urandom, a, ($urandom_range(0, 3) == 0) ? a : $urandom);
        end

        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
